int_free_list: RTL and testbench

INT_FREE_LIST -- requirements
Module: int_free_list

---
 rtl/int_fl_pkg.sv | 16 +
 rtl/int_free_list.sv | 98 +++++++++
 tb/tb_int_free_list.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/int_fl_pkg.sv
// Shared defaults and width constants for the integer physical-register free list.
package int_fl_pkg;

    localparam int FL_ENTRY_W     = 5;
    localparam int FL_DEPTH       = 8;
    localparam int FL_INIT_BASE   = 3;
    localparam int FL_INIT_STRIDE = 4;
    localparam int FL_PTR_W       = $clog2(FL_DEPTH);
    localparam int FL_CNT_W       = FL_PTR_W + 1;

    // Untruncated initial ID of a slot; callers cut it down to their entry width.
    function automatic int flInitId(input int base, input int stride, input int idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/int_free_list.sv
// Circular free list of physical register IDs with two allocate lanes and two
// release lanes per cycle, all-or-nothing grants and a sticky overflow flag.
module int_free_list
    import int_fl_pkg::*;
#(
    parameter int ENTRY_W     = FL_ENTRY_W,
    parameter int DEPTH       = FL_DEPTH,
    parameter int INIT_BASE   = FL_INIT_BASE,
    parameter int INIT_STRIDE = FL_INIT_STRIDE
) (
    input  logic                     Clk,
    input  logic                     Rest,
    input  logic [1:0]               AllocReq,
    output logic                     AllocGnt,
    output logic [ENTRY_W-1:0]       AllocId0,
    output logic [ENTRY_W-1:0]       AllocId1,
    input  logic [1:0]               FreeVld,
    input  logic [ENTRY_W-1:0]       FreeId0,
    input  logic [ENTRY_W-1:0]       FreeId1,
    input  logic                     Clean,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty,
    output logic                     Full,
    output logic                     OvfErr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    logic [ENTRY_W-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    logic [1:0]         allocN, grantN, freeN;
    logic [CNT_W:0]     postCount;
    logic               overflow, wrEn0, wrEn1;
    logic [ENTRY_W-1:0] wrId0;

    // Grants look only at the registered count, so a same-cycle release never feeds an allocation.
    always_comb begin
        allocN    = popcount2(AllocReq);
        AllocGnt  = (AllocReq != 2'b00) && (count_q >= CNT_W'(allocN));
        grantN    = AllocGnt ? allocN : 2'b00;
        freeN     = popcount2(FreeVld);
        AllocId0  = slot_q[head_q];
        AllocId1  = (AllocReq == 2'b10) ? slot_q[head_q] : slot_q[head_q + PTR_W'(1)];
        postCount = {1'b0, count_q} - (CNT_W+1)'(grantN) + (CNT_W+1)'(freeN);
        overflow  = postCount > (CNT_W+1)'(DEPTH);
        wrEn0     = !Clean && !overflow && (FreeVld != 2'b00);
        wrEn1     = !Clean && !overflow && (FreeVld == 2'b11);
        wrId0     = FreeVld[0] ? FreeId0 : FreeId1;

        head_d  = head_q + PTR_W'(grantN);
        tail_d  = overflow ? tail_q : tail_q + PTR_W'(freeN);
        count_d = overflow ? count_q - CNT_W'(grantN) : postCount[CNT_W-1:0];
        ovf_d   = ovf_q | (overflow && !Clean);
        if (Clean) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= ENTRY_W'(flInitId(INIT_BASE, INIT_STRIDE, i));
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (Clean) begin
                for (int i = 0; i < DEPTH; i++)
                    slot_q[i] <= ENTRY_W'(flInitId(INIT_BASE, INIT_STRIDE, i));
            end else begin
                if (wrEn0) slot_q[tail_q] <= wrId0;
                if (wrEn1) slot_q[tail_q + PTR_W'(1)] <= FreeId1;
            end
        end
    end

    assign Count  = count_q;
    assign Empty  = (count_q == '0);
    assign Full   = (count_q == CNT_W'(DEPTH));
    assign OvfErr = ovf_q;

endmodule

// File: tb/tb_int_free_list.sv
// Bench for int_free_list: a queue model of the free IDs predicts every cycle,
// predictions go through a scoreboard and are compared once the DUT responds.
module tb_int_free_list;

    logic       Clk = 1'b0;
    logic       Rest;
    logic [1:0] AllocReq;
    logic       AllocGnt;
    logic [4:0] AllocId0, AllocId1;
    logic [1:0] FreeVld;
    logic [4:0] FreeId0, FreeId1;
    logic       Clean;
    logic [3:0] Count;
    logic       Empty, Full, OvfErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       gnt;
        logic [4:0] id0;
        logic [4:0] id1;
        bit         chk0;
        bit         chk1;
        int         count;
        logic       ovf;
    } exp_t;

    exp_t sbQ[$];
    int   freeQ[$];
    logic modelOvf;
    int   initIds[8] = '{3, 7, 11, 15, 19, 23, 27, 31};

    int_free_list #(
        .ENTRY_W(5), .DEPTH(8), .INIT_BASE(3), .INIT_STRIDE(4)
    ) dut (
        .Clk(Clk), .Rest(Rest),
        .AllocReq(AllocReq), .AllocGnt(AllocGnt),
        .AllocId0(AllocId0), .AllocId1(AllocId1),
        .FreeVld(FreeVld), .FreeId0(FreeId0), .FreeId1(FreeId1),
        .Clean(Clean), .Count(Count), .Empty(Empty), .Full(Full), .OvfErr(OvfErr)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        freeQ.delete();
        foreach (initIds[i]) freeQ.push_back(initIds[i]);
    endtask

    // Drive one cycle of stimulus and push the model's prediction for it.
    task automatic applyStimulus(input string tag, input logic [1:0] req, input logic [1:0] fv,
                                 input logic [4:0] f0, input logic [4:0] f1, input logic cl);
        exp_t e;
        int   n, nf, granted;
        @(negedge Clk);
        AllocReq = req;
        FreeVld  = fv;
        FreeId0  = f0;
        FreeId1  = f1;
        Clean    = cl;
        n  = int'(req[0]) + int'(req[1]);
        nf = int'(fv[0]) + int'(fv[1]);
        e.tag  = tag;
        e.gnt  = (req != 2'b00) && (freeQ.size() >= n);
        e.chk0 = freeQ.size() >= 1;
        e.id0  = e.chk0 ? 5'(freeQ[0]) : 5'd0;
        if (req == 2'b10) begin
            e.chk1 = freeQ.size() >= 1;
            e.id1  = e.chk1 ? 5'(freeQ[0]) : 5'd0;
        end else begin
            e.chk1 = freeQ.size() >= 2;
            e.id1  = e.chk1 ? 5'(freeQ[1]) : 5'd0;
        end
        if (cl) begin
            modelReset();
        end else begin
            granted = e.gnt ? n : 0;
            repeat (granted) void'(freeQ.pop_front());
            if (freeQ.size() + nf > 8) begin
                modelOvf = 1'b1;
            end else begin
                if (fv[0]) freeQ.push_back(int'(f0));
                if (fv[1]) freeQ.push_back(int'(f1));
            end
        end
        e.count = freeQ.size();
        e.ovf   = modelOvf;
        sbQ.push_back(e);
    endtask

    // Pop the prediction: lookahead outputs before the edge, state after it.
    task automatic checkOutput();
        exp_t e;
        #1;
        e = sbQ.pop_front();
        check({e.tag, ".gnt"}, 32'(AllocGnt), 32'(e.gnt));
        if (e.chk0) check({e.tag, ".id0"}, 32'(AllocId0), 32'(e.id0));
        if (e.chk1) check({e.tag, ".id1"}, 32'(AllocId1), 32'(e.id1));
        @(posedge Clk);
        #1;
        check({e.tag, ".count"}, 32'(Count), 32'(e.count));
        check({e.tag, ".empty"}, 32'(Empty), 32'(e.count == 0));
        check({e.tag, ".full"}, 32'(Full), 32'(e.count == 8));
        check({e.tag, ".ovf"}, 32'(OvfErr), 32'(e.ovf));
    endtask

    task automatic step(input string tag, input logic [1:0] req, input logic [1:0] fv,
                        input logic [4:0] f0, input logic [4:0] f1, input logic cl);
        applyStimulus(tag, req, fv, f0, f1, cl);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rest     = 1'b0;
        AllocReq = 2'b00;
        FreeVld  = 2'b00;
        FreeId0  = '0;
        FreeId1  = '0;
        Clean    = 1'b0;
        modelOvf = 1'b0;
        modelReset();

        #12;
        check("rst.count", 32'(Count), 32'd8);
        check("rst.full", 32'(Full), 32'd1);
        check("rst.empty", 32'(Empty), 32'd0);
        check("rst.gnt", 32'(AllocGnt), 32'd0);
        check("rst.id0", 32'(AllocId0), 32'd3);
        check("rst.id1", 32'(AllocId1), 32'd7);
        check("rst.ovf", 32'(OvfErr), 32'd0);
        @(negedge Clk);
        Rest = 1'b1;

        for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
        step("emptyDeny", 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
        step("wrapFree", 2'b00, 2'b11, 5'd5, 5'd9, 1'b0);
        step("wrapAlloc", 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
        step("free12", 2'b00, 2'b01, 5'd12, 5'd0, 1'b0);
        step("simul", 2'b11, 2'b01, 5'd20, 5'd0, 1'b0);
        step("lane1Only", 2'b10, 2'b10, 5'd0, 5'd17, 1'b0);
        step("clean", 2'b00, 2'b00, 5'd0, 5'd0, 1'b1);
        step("ovf", 2'b00, 2'b01, 5'd1, 5'd0, 1'b0);
        step("alloc2a", 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
        step("alloc2b", 2'b11, 2'b00, 5'd0, 5'd0, 1'b0);
        step("alloc1", 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
        step("midClean", 2'b11, 2'b11, 5'd2, 5'd6, 1'b1);

        for (int i = 0; i < 40; i++) begin
            step($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 15) == 0));
        end

        @(negedge Clk);
        #2;
        Rest = 1'b0;
        #1;
        check("asyncRst.count", 32'(Count), 32'd8);
        check("asyncRst.ovf", 32'(OvfErr), 32'd0);
        check("asyncRst.id0", 32'(AllocId0), 32'd3);
        #10;
        Rest = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
